// File: rtl/jk_bank_sequencer.sv
// jk_bank_sequencer: command sequencer driving a WIDTH-bit bank of JK flip-flops.
// Commands arrive over a valid/ready handshake and are executed as clear, set, toggle,
// load, count up/down or shift-left operations. A one-cycle done pulse marks completion.
// Optional feature macro: JK_WRAP_FLAG_EN adds a 'wrap' output that pulses after a
// counting edge wraps around the bank range.
module jk_bank_sequencer #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             async_reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [CNT_W-1:0] cmd_count,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic             busy,
    output logic             done
`ifdef JK_WRAP_FLAG_EN
    ,
    output logic             wrap
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        OP_NOP    = 3'd0,
        OP_CLEAR  = 3'd1,
        OP_SET    = 3'd2,
        OP_TOGGLE = 3'd3,
        OP_LOAD   = 3'd4,
        OP_UP     = 3'd5,
        OP_DOWN   = 3'd6,
        OP_SHIFT  = 3'd7
    } op_t;

    state_t           state;
    state_t           next_state;
    op_t              op_r;
    logic [WIDTH-1:0] data_r;
    logic [CNT_W-1:0] cnt_r;
    logic             accept;
    logic             multi_cycle;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic [WIDTH-1:0] up_t;
    logic [WIDTH-1:0] dn_t;
    logic [WIDTH-1:0] low_mask;

    assign cmd_ready   = (state == IDLE);
    assign busy        = (state == EXEC) || (state == DONE);
    assign done        = (state == DONE);
    assign accept      = cmd_valid && cmd_ready;
    assign multi_cycle = (cmd_op >= 3'd5);
    assign qb          = ~q;

    // State register; reset aborts any command in flight without a done pulse.
    always_ff @(posedge clk or posedge async_reset) begin
        if (async_reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: one EXEC pass per remaining count, then a single DONE cycle.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = EXEC;
            EXEC:    if (cnt_r == CNT_W'(1)) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Latch the command on accept; a zero count on a repeating op becomes a one-cycle NOP.
    always_ff @(posedge clk or posedge async_reset) begin
        if (async_reset) begin
            op_r   <= OP_NOP;
            data_r <= '0;
            cnt_r  <= '0;
        end else if (accept) begin
            data_r <= cmd_data;
            if (multi_cycle && (cmd_count == '0)) begin
                op_r  <= OP_NOP;
                cnt_r <= CNT_W'(1);
            end else begin
                op_r  <= op_t'(cmd_op);
                cnt_r <= multi_cycle ? cmd_count : CNT_W'(1);
            end
        end else if (state == EXEC) begin
            cnt_r <= cnt_r - CNT_W'(1);
        end
    end

    // Per-bit J/K drive; counters use the AND of all lower bits of q (or qb) as toggle enable.
    always_comb begin
        j        = '0;
        k        = '0;
        up_t     = '0;
        dn_t     = '0;
        low_mask = '0;
        for (int i = 0; i < WIDTH; i++) begin
            low_mask = (WIDTH'(1) << i) - WIDTH'(1);
            up_t[i]  = &(q | ~low_mask);
            dn_t[i]  = &(qb | ~low_mask);
        end
        if (state == EXEC) begin
            case (op_r)
                OP_NOP:    begin j = '0;      k = '0;      end
                OP_CLEAR:  begin j = '0;      k = '1;      end
                OP_SET:    begin j = '1;      k = '0;      end
                OP_TOGGLE: begin j = data_r;  k = data_r;  end
                OP_LOAD:   begin j = data_r;  k = ~data_r; end
                OP_UP:     begin j = up_t;    k = up_t;    end
                OP_DOWN:   begin j = dn_t;    k = dn_t;    end
                OP_SHIFT:  begin
                    j = {q[WIDTH-2:0], data_r[0]};
                    k = ~{q[WIDTH-2:0], data_r[0]};
                end
                default:   begin j = '0;      k = '0;      end
            endcase
        end
    end

    // JK flip-flop bank: 00 hold, 01 clear, 10 set, 11 toggle.
    always_ff @(posedge clk or posedge async_reset) begin
        if (async_reset) begin
            q <= '0;
        end else begin
            q <= (j & ~q) | (~k & q);
        end
    end

`ifdef JK_WRAP_FLAG_EN
    // Wrap flag is high for the cycle following a counting edge that crosses all-ones/zero.
    always_ff @(posedge clk or posedge async_reset) begin
        if (async_reset) begin
            wrap <= 1'b0;
        end else begin
            wrap <= (state == EXEC) &&
                    (((op_r == OP_UP) && (&q)) || ((op_r == OP_DOWN) && (q == '0)));
        end
    end
`endif

endmodule

// File: tb/tb_jk_bank_sequencer.sv
// Self-checking bench for jk_bank_sequencer with a behavioural model of the bank value.
// Honours JK_WRAP_FLAG_EN when the design is built with the wrap output.
module tb_jk_bank_sequencer;

    localparam int W  = 8;
    localparam int CW = 8;

    logic          clk;
    logic          async_reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [2:0]    cmd_op;
    logic [W-1:0]  cmd_data;
    logic [CW-1:0] cmd_count;
    logic [W-1:0]  q;
    logic [W-1:0]  qb;
    logic          busy;
    logic          done;
`ifdef JK_WRAP_FLAG_EN
    logic          wrap;
`endif

    int           errors = 0;
    int           checks = 0;
    logic [W-1:0] model_q;

    jk_bank_sequencer #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk         (clk),
        .async_reset (async_reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_data    (cmd_data),
        .cmd_count   (cmd_count),
        .q           (q),
        .qb          (qb),
        .busy        (busy),
        .done        (done)
`ifdef JK_WRAP_FLAG_EN
        ,
        .wrap        (wrap)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected bank value after one execution edge, from the opcode's meaning.
    function automatic logic [W-1:0] model_next(input logic [2:0] op, input logic [W-1:0] cur,
                                                input logic [W-1:0] d, input int cnt);
        logic [W-1:0] one;
        one = W'(1);
        if (op >= 3'd5 && cnt == 0) return cur;
        case (op)
            3'd0:    return cur;
            3'd1:    return '0;
            3'd2:    return '1;
            3'd3:    return cur ^ d;
            3'd4:    return d;
            3'd5:    return cur + one;
            3'd6:    return cur - one;
            default: return (cur << 1) | (d & one);
        endcase
    endfunction

    // Run one command end to end, checking every cycle; chaos keeps valid high with junk inputs.
    task automatic do_cmd(input logic [2:0] op, input logic [W-1:0] data, input int cnt,
                          input logic chaos);
        int guard;
        int n_exec;
        logic [W-1:0] prev;
        logic wrap_exp;
        guard = 0;
        while (cmd_ready !== 1'b1 && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ready_wait: cmd_ready=%b required 1", cmd_ready);
        end
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        cmd_count = CW'(cnt);
        @(posedge clk); #1;
        if (!chaos) cmd_valid = 1'b0;
        n_exec = (op >= 3'd5) ? ((cnt == 0) ? 1 : cnt) : 1;
        for (int s = 0; s < n_exec; s++) begin
            checks++;
            if (busy !== 1'b1 || done !== 1'b0 || cmd_ready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL exec_flags op=%0d step=%0d: busy=%b done=%b ready=%b required 1 0 0",
                         op, s, busy, done, cmd_ready);
            end
            if (chaos) begin
                cmd_op    = 3'($urandom);
                cmd_data  = W'($urandom);
                cmd_count = CW'($urandom);
            end
            @(posedge clk); #1;
            prev     = model_q;
            model_q  = model_next(op, model_q, data, cnt);
            wrap_exp = (cnt != 0) && (((op == 3'd5) && (prev == '1)) || ((op == 3'd6) && (prev == '0)));
            checks++;
            if (q !== model_q || qb !== ~model_q) begin
                errors++;
                $display("[TB] FAIL bank op=%0d step=%0d: q=%h qb=%h required q=%h qb=%h",
                         op, s, q, qb, model_q, ~model_q);
            end
`ifdef JK_WRAP_FLAG_EN
            checks++;
            if (wrap !== wrap_exp) begin
                errors++;
                $display("[TB] FAIL wrap op=%0d step=%0d: wrap=%b required %b", op, s, wrap, wrap_exp);
            end
`else
            if (wrap_exp) $display("[TB] note: wrap edge at step %0d", s);
`endif
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b1 || cmd_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL done_cycle op=%0d: done=%b busy=%b ready=%b required 1 1 0",
                     op, done, busy, cmd_ready);
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1 || q !== model_q) begin
            errors++;
            $display("[TB] FAIL return_idle op=%0d: done=%b busy=%b ready=%b q=%h required 0 0 1 q=%h",
                     op, done, busy, cmd_ready, q, model_q);
        end
`ifdef JK_WRAP_FLAG_EN
        checks++;
        if (wrap !== 1'b0) begin
            errors++;
            $display("[TB] FAIL wrap_idle: wrap=%b required 0", wrap);
        end
`endif
    endtask

    // Check the reset values of every output.
    task automatic check_reset_state(input string tag);
        checks++;
        if (q !== '0 || qb !== '1 || busy !== 1'b0 || done !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s: q=%h qb=%h busy=%b done=%b ready=%b required 00 ff 0 0 1",
                     tag, q, qb, busy, done, cmd_ready);
        end
    endtask

    task automatic test_reset;
        cmd_valid   = 1'b0;
        cmd_op      = '0;
        cmd_data    = '0;
        cmd_count   = '0;
        async_reset = 1'b1;
        #12;
        check_reset_state("reset_initial");
        async_reset = 1'b0;
        @(posedge clk); #1;
        model_q = '0;
        do_cmd(3'd2, '0, 0, 1'b0);
        // Mid-cycle pulse must clear the bank immediately, without a clock edge.
        #3;
        async_reset = 1'b1;
        #1;
        check_reset_state("reset_async_pulse");
        #2;
        async_reset = 1'b0;
        model_q = '0;
        @(posedge clk); #1;
    endtask

    task automatic test_load;
        do_cmd(3'd4, 8'hA5, 0, 1'b0);
        checks++;
        if (q !== 8'hA5 || qb !== 8'h5A) begin
            errors++;
            $display("[TB] FAIL load_value: q=%h qb=%h required a5 5a", q, qb);
        end
    endtask

    task automatic test_toggle_set_clear;
        do_cmd(3'd3, 8'h0F, 0, 1'b0);
        checks++;
        if (q !== 8'hAA) begin
            errors++;
            $display("[TB] FAIL toggle_value: q=%h required aa", q);
        end
        do_cmd(3'd2, 8'h00, 0, 1'b0);
        do_cmd(3'd1, 8'hFF, 0, 1'b0);
        do_cmd(3'd0, 8'h3C, 0, 1'b0);
    endtask

    task automatic test_count_up_wrap;
        do_cmd(3'd4, 8'hFC, 0, 1'b0);
        do_cmd(3'd5, 8'h00, 6, 1'b0);
        checks++;
        if (q !== 8'h02) begin
            errors++;
            $display("[TB] FAIL count_up_end: q=%h required 02", q);
        end
    endtask

    task automatic test_count_down_shift;
        do_cmd(3'd4, 8'h01, 0, 1'b0);
        do_cmd(3'd6, 8'h00, 3, 1'b0);
        do_cmd(3'd7, 8'h01, 2, 1'b0);
        checks++;
        if (q !== 8'hFB) begin
            errors++;
            $display("[TB] FAIL shift_end: q=%h required fb", q);
        end
        do_cmd(3'd5, 8'h00, 0, 1'b0);
        do_cmd(3'd7, 8'h00, 0, 1'b0);
        do_cmd(3'd7, 8'h00, 9, 1'b0);
    endtask

    task automatic test_handshake;
        do_cmd(3'd5, 8'h00, 4, 1'b1);
        do_cmd(3'd3, 8'h81, 0, 1'b1);
        do_cmd(3'd6, 8'h00, 3, 1'b1);
    endtask

    task automatic test_mid_reset;
        do_cmd(3'd4, 8'h40, 0, 1'b0);
        cmd_valid = 1'b1;
        cmd_op    = 3'd5;
        cmd_count = CW'(100);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
        end
        checks++;
        if (busy !== 1'b1 || q !== 8'h4A) begin
            errors++;
            $display("[TB] FAIL mid_count: busy=%b q=%h required 1 4a", busy, q);
        end
        #2;
        async_reset = 1'b1;
        #1;
        check_reset_state("mid_reset_assert");
        #2;
        async_reset = 1'b0;
        model_q = '0;
        repeat (4) begin
            @(posedge clk); #1;
            check_reset_state("mid_reset_no_resume");
        end
    endtask

    task automatic test_random;
        logic [2:0]   op;
        logic [W-1:0] d;
        int           c;
        for (int n = 0; n < 30; n++) begin
            op = 3'($urandom_range(0, 7));
            d  = W'($urandom);
            c  = $urandom_range(0, 5);
            do_cmd(op, d, c, (($urandom & 32'd3) == 32'd0) ? 1'b1 : 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_toggle_set_clear();
        test_count_up_wrap();
        test_count_down_shift();
        test_handshake();
        test_mid_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
